// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: steps each instruction through FETCH/DECODE/EXECUTE/WRITEBACK,
// owns the PC, input-wait handshake, halt/resume and soft reset; all outputs are registered.
module instr_sequencer #(
  parameter int unsigned     PC_W     = 8,
  parameter int unsigned     CNT_W    = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cu_writeReg,
  input  logic             cu_writeEnable,
  input  logic             cu_Branch,
  input  logic [1:0]       cu_Jump,
  input  logic             cu_inSignal,
  input  logic             cu_showDisplay,
  input  logic             cu_hlt,
  input  logic             cu_reset,
  input  logic             branch_cond,
  input  logic [PC_W-1:0]  branch_target,
  input  logic [PC_W-1:0]  jump_target,
  input  logic [PC_W-1:0]  jr_target,
  input  logic             in_valid,
  input  logic             resume,
  output logic [PC_W-1:0]  pc,
  output logic             ir_load,
  output logic             reg_we,
  output logic             mem_we,
  output logic             display_load,
  output logic             in_ack,
  output logic             waiting_input,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  // state     | meaning
  // FETCH     | ir_load pulses, instruction register captures imem
  // DECODE    | decode inputs valid; soft reset / halt / input dispatch
  // EXECUTE   | ALU settle cycle
  // WRITEBACK | the only cycle carrying architectural write strobes; PC update
  // WAIT_IN   | waiting for in_valid, acks it, then EXECUTE
  // HALT      | PC held until resume
  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_WAIT_IN   = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_n;
  logic [PC_W-1:0]  pc_n;
  logic             cnt_inc;
  logic             dec_load;
  logic             in_ack_n;

  // decode fields captured in DECODE, already forced to known values
  logic dec_wr_q, dec_we_q, dec_br_q, dec_jmp_q, dec_jr_q, dec_disp_q;
  logic dec_wr_n, dec_we_n, dec_br_n, dec_jmp_n, dec_jr_n, dec_disp_n;

  // if-else chains rather than ternaries so an unknown input resolves to 0
  always_comb begin
    dec_wr_n   = 1'b0;
    dec_we_n   = 1'b0;
    dec_br_n   = 1'b0;
    dec_jmp_n  = 1'b0;
    dec_jr_n   = 1'b0;
    dec_disp_n = 1'b0;
    if (cu_writeReg)    dec_wr_n   = 1'b1;
    if (cu_writeEnable) dec_we_n   = 1'b1;
    if (cu_Branch)      dec_br_n   = 1'b1;
    if (cu_showDisplay) dec_disp_n = 1'b1;
    if (cu_Jump == 2'b01)      dec_jmp_n = 1'b1;
    else if (cu_Jump == 2'b10) dec_jr_n  = 1'b1;
  end

  always_comb begin
    state_n  = S_FETCH;
    pc_n     = pc;
    cnt_inc  = 1'b0;
    dec_load = 1'b0;
    in_ack_n = 1'b0;
    case (state_q)
      S_FETCH: state_n = S_DECODE;
      S_DECODE: begin
        dec_load = 1'b1;
        if (cu_reset) begin
          state_n = S_FETCH;
          pc_n    = RESET_PC;
        end else if (cu_hlt) begin
          state_n = S_HALT;
        end else if (cu_inSignal) begin
          state_n = S_WAIT_IN;
        end else begin
          state_n = S_EXECUTE;
        end
      end
      S_EXECUTE: state_n = S_WRITEBACK;
      S_WRITEBACK: begin
        state_n = S_FETCH;
        cnt_inc = 1'b1;
        if (dec_jmp_q)                    pc_n = jump_target;
        else if (dec_jr_q)                pc_n = jr_target;
        else if (dec_br_q && branch_cond) pc_n = branch_target;
        else                              pc_n = pc + PC_ONE;
      end
      S_WAIT_IN: begin
        if (in_valid) begin
          state_n  = S_EXECUTE;
          in_ack_n = 1'b1;
        end else begin
          state_n = S_WAIT_IN;
        end
      end
      S_HALT: begin
        if (resume) begin
          state_n = S_FETCH;
          pc_n    = pc + PC_ONE;
          cnt_inc = 1'b1;
        end else begin
          state_n = S_HALT;
        end
      end
      default: state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_wr_q   <= 1'b0;
      dec_we_q   <= 1'b0;
      dec_br_q   <= 1'b0;
      dec_jmp_q  <= 1'b0;
      dec_jr_q   <= 1'b0;
      dec_disp_q <= 1'b0;
    end else if (dec_load) begin
      dec_wr_q   <= dec_wr_n;
      dec_we_q   <= dec_we_n;
      dec_br_q   <= dec_br_n;
      dec_jmp_q  <= dec_jmp_n;
      dec_jr_q   <= dec_jr_n;
      dec_disp_q <= dec_disp_n;
    end
  end

  // outputs are registered from the next state, so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_PC;
      instr_count   <= '0;
      ir_load       <= 1'b0;
      reg_we        <= 1'b0;
      mem_we        <= 1'b0;
      display_load  <= 1'b0;
      in_ack        <= 1'b0;
      waiting_input <= 1'b0;
      halted        <= 1'b0;
    end else begin
      pc            <= pc_n;
      if (cnt_inc && (instr_count != '1)) instr_count <= instr_count + CNT_ONE;
      ir_load       <= (state_n == S_FETCH);
      reg_we        <= (state_n == S_WRITEBACK) && dec_wr_q;
      mem_we        <= (state_n == S_WRITEBACK) && dec_we_q;
      display_load  <= (state_n == S_WRITEBACK) && dec_disp_q;
      in_ack        <= in_ack_n;
      waiting_input <= (state_n == S_WAIT_IN);
      halted        <= (state_n == S_HALT);
    end
  end

  assign state = state_q;

endmodule
